mssd_port_collector: RTL
========================

# mssd_port_collector

Downstream stage of the MSSD receive controller: consumes the serialized payload (`SerOut` qualified by `SerOut_Valid`) and the end-of-frame `done` strobe. It collects the bits into parallel words tagged with the destination port latched at frame start, and emits them on a single-beat valid interface. Partial trailing words are flushed with a bit count. It also drives a one-hot port activity indicator.

## Interface
- `WORD_W`, default 8: assembled word width in bits (≥2).
- `CNT_W`, default 8: width of each per-port frame counter (only used with `MSSD_FRAME_STATS_EN`).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  single-`clk`-cycle strobe, same one that advances the controller; bits are sampled only when high.
- `port_sel`  in  2  destination port from the controller's address register; stable while `SerOut_Valid`/`done` are high.
- `SerOut`  in  1  serial payload bit, MSB first.
- `SerOut_Valid`  in  1  `SerOut` is a payload bit this `clk_en`.
- `done`  in  1  frame end from controller.
- `word_out`  out  WORD_W  assembled word, right-aligned.
- `word_port`  out  2  port the word belongs to.
- `word_bits`  out  $clog2(WORD_W+1)  number of valid bits in `word_out` (1..WORD_W).
- `word_valid`  out  1  one-`clk` pulse: `word_out`/`word_port`/`word_bits` valid.
- `frame_end`  out  1  one-`clk` pulse: frame completed on `word_port`.
- `busy`  out  1  high while in COLLECT or FLUSH.
- `p_en`  out  4  one-hot active port; held from frame start until the next frame starts.
- `frame_cnt`  out  4*CNT_W  per-port frame counters, port 0 in LSBs (present only with `MSSD_FRAME_STATS_EN`).

## Operation
- FSM states: IDLE, COLLECT, FLUSH. All transitions and sampling are qualified by `clk_en`, except FLUSH→IDLE, which is unconditional.
- IDLE:
  - `clk_en & SerOut_Valid`: latch `port_sel` into `port_q`, set `p_en = 1<<port_sel`, shift reg = `SerOut`, `cnt = 1`, go to COLLECT.
  - `clk_en & done` with no bits (zero-length frame): latch port, pulse `frame_end` with `word_valid=0`, stay in IDLE.
- COLLECT, `clk_en & SerOut_Valid`: `sr <= {sr[WORD_W-2:0], SerOut}`, `cnt++`.
  - When `cnt` reaches WORD_W: pulse `word_valid` with `word_bits=WORD_W`, then `cnt <= 0`, stay in COLLECT.
- COLLECT, `clk_en & done`:
  - `cnt>0`: go to FLUSH.
  - `cnt==0`: pulse `frame_end` alone and return to IDLE.
- FLUSH: one `clk`. Drive `word_out = sr` (low `cnt` bits meaningful, upper bits zero), `word_bits=cnt`, and pulse `word_valid` and `frame_end` together. Clear `cnt`, go to IDLE.
- `done` and `SerOut_Valid` both high on the same `clk_en`: `done` wins and the bit is discarded.
- `port_q` is frozen for the whole frame; `port_sel` changes mid-frame are ignored.
- `rst` low at any time: immediate return to IDLE, partial word discarded, no flush pulse.

## Timing
- All outputs are registered.
- Reset values: `word_out=0`, `word_port=0`, `word_bits=0`, `word_valid=0`, `frame_end=0`, `busy=0`, `p_en=4'b0000`, `frame_cnt=0`.
- Latency:
  - Full word: `word_valid` is high the `clk` after the `clk_en` edge that sampled the WORD_W-th bit.
  - Flush: `word_valid`/`frame_end` are high 2 `clk` after the `done` sample.
- `word_out`, `word_port` and `word_bits` hold their last value until the next `word_valid`.
- No backpressure: the consumer must accept every pulse.
- Minimum `clk_en` spacing is 2 `clk`, guaranteeing FLUSH completes before the next sample.

## Configuration
- `MSSD_FRAME_STATS_EN` defined: `frame_cnt` port and the per-port counters exist.
  - Counter for `port_q` increments on every `frame_end` pulse, including zero-length frames.
  - Counters saturate at 2^CNT_W-1.
  - Counters reset to 0 via `rst`.
- `MSSD_FRAME_STATS_EN` undefined: port and counters are absent. All other behaviour is identical.

## Structure
- `mssd_pkg` holds:
  - the FSM state enum (IDLE/COLLECT/FLUSH),
  - `MSSD_PORTS=4`,
  - `MSSD_PORT_W=2`.
- Sub-module `mssd_frame_stats` (saturating counter bank, inputs `frame_end`/`port_q`) is instantiated only under `MSSD_FRAME_STATS_EN`.

## Test plan
- Full word: WORD_W=8, `port_sel=2`, bits 1,0,1,1,0,0,1,0, then `done` → `word_out=8'hB2`, `word_port=2`, `word_bits=8`, `p_en=4'b0100`; next `done` gives `frame_end` with `word_valid=0`.
- Partial word: `port_sel=1`, bits 1,0,1, then `done` → single flush beat with `word_out=8'h05`, `word_bits=3`, `word_valid=frame_end=1`.
- Multi-word: 10 bits on port 3 (8'hFF then 1,0) → `8'hFF`/bits 8, then flush `8'h02`/bits 2 with `frame_end`; `frame_cnt[3]` increments by 1 (macro on).
- Zero-length and collision cases:
  - `done` in IDLE → `frame_end` pulse only, `busy` stays 0.
  - `done` and `SerOut_Valid` together → bit dropped.
- Reset mid-frame: `rst` low after 5 bits → all outputs are reset values immediately, no `word_valid`; next frame starts cleanly with `cnt=1`.

Source files
------------

// File: rtl/mssd_pkg.sv
// mssd_pkg: shared definitions for the MSSD receive-side port collector.
//   mssd_state_e  - collector FSM states (IDLE / COLLECT / FLUSH)
//   MSSD_PORTS    - number of destination ports
//   MSSD_PORT_W   - width of a port index
//   port_onehot() - port index to one-hot activity vector
package mssd_pkg;

    localparam int MSSD_PORTS  = 4;
    localparam int MSSD_PORT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH
    } mssd_state_e;

    function automatic logic [MSSD_PORTS-1:0] port_onehot(input logic [MSSD_PORT_W-1:0] p);
        port_onehot    = '0;
        port_onehot[p] = 1'b1;
    endfunction

endpackage

// File: rtl/mssd_port_collector_if.sv
// mssd_port_collector_if: serial payload input and assembled-word output
// bundle of the MSSD port collector.
//   master : controller/consumer side (drives port_sel, SerOut, SerOut_Valid, done)
//   slave  : collector side (drives word_out, word_port, word_bits, word_valid,
//            frame_end, busy, p_en)
interface mssd_port_collector_if #(
    parameter int WORD_W = 8
);
    localparam int BITS_W = $clog2(WORD_W + 1);

    logic [mssd_pkg::MSSD_PORT_W-1:0] port_sel;
    logic                             SerOut;
    logic                             SerOut_Valid;
    logic                             done;

    logic [WORD_W-1:0]                word_out;
    logic [mssd_pkg::MSSD_PORT_W-1:0] word_port;
    logic [BITS_W-1:0]                word_bits;
    logic                             word_valid;
    logic                             frame_end;
    logic                             busy;
    logic [mssd_pkg::MSSD_PORTS-1:0]  p_en;

    modport master (
        output port_sel, SerOut, SerOut_Valid, done,
        input  word_out, word_port, word_bits, word_valid, frame_end, busy, p_en
    );

    modport slave (
        input  port_sel, SerOut, SerOut_Valid, done,
        output word_out, word_port, word_bits, word_valid, frame_end, busy, p_en
    );

endinterface

// File: rtl/mssd_frame_stats.sv
// mssd_frame_stats: bank of MSSD_PORTS saturating frame counters.
//   clk, rst   - clock, asynchronous active-low reset
//   frame_end  - one-clk frame completion pulse
//   port_q     - port the completed frame belongs to
//   frame_cnt  - per-port counters, port 0 in the LSBs
module mssd_frame_stats
    import mssd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_end,
    input  logic [MSSD_PORT_W-1:0]      port_q,
    output logic [MSSD_PORTS*CNT_W-1:0] frame_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            for (int unsigned i = 0; i < MSSD_PORTS; i++) begin
                if (port_q == MSSD_PORT_W'(i) && frame_cnt[i*CNT_W +: CNT_W] != '1) begin
                    frame_cnt[i*CNT_W +: CNT_W] <= frame_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mssd_port_collector.sv
// mssd_port_collector: collects the MSSD serial payload into WORD_W-bit words
// tagged with the port latched at frame start; trailing partial words are
// flushed with their bit count. Optional per-port frame counters are built
// when MSSD_FRAME_STATS_EN is defined.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   clk_en    - sampling strobe shared with the controller
//   bus       - mssd_port_collector_if.slave (serial in, word out, busy, p_en)
//   frame_cnt - per-port frame counters (MSSD_FRAME_STATS_EN only)
module mssd_port_collector
    import mssd_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    mssd_port_collector_if.slave        bus
`ifdef MSSD_FRAME_STATS_EN
    ,
    output logic [MSSD_PORTS*CNT_W-1:0] frame_cnt
`endif
);

    localparam int BITS_W = $clog2(WORD_W + 1);

    mssd_state_e            state;
    logic [MSSD_PORT_W-1:0] port_q;
    logic [WORD_W-1:0]      sr;
    logic [WORD_W-1:0]      sr_next;
    logic [BITS_W-1:0]      cnt;
    logic [WORD_W-1:0]      flush_mask;

    assign sr_next = {sr[WORD_W-2:0], bus.SerOut};

    // sr keeps bits of earlier full words above the partial one; only the
    // low cnt bits belong to the flushed word.
    always_comb begin
        flush_mask = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            flush_mask[i] = (i < 32'(cnt));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            port_q         <= '0;
            sr             <= '0;
            cnt            <= '0;
            bus.word_out   <= '0;
            bus.word_port  <= '0;
            bus.word_bits  <= '0;
            bus.word_valid <= 1'b0;
            bus.frame_end  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.p_en       <= '0;
        end else begin
            bus.word_valid <= 1'b0;
            bus.frame_end  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clk_en) begin
                        if (bus.done) begin
                            // zero-length frame
                            port_q        <= bus.port_sel;
                            bus.p_en      <= port_onehot(bus.port_sel);
                            bus.frame_end <= 1'b1;
                        end else if (bus.SerOut_Valid) begin
                            port_q   <= bus.port_sel;
                            bus.p_en <= port_onehot(bus.port_sel);
                            sr       <= WORD_W'(bus.SerOut);
                            cnt      <= BITS_W'(1);
                            bus.busy <= 1'b1;
                            state    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (clk_en) begin
                        if (bus.done) begin
                            if (cnt != '0) begin
                                state <= FLUSH;
                            end else begin
                                bus.frame_end <= 1'b1;
                                bus.busy      <= 1'b0;
                                state         <= IDLE;
                            end
                        end else if (bus.SerOut_Valid) begin
                            sr <= sr_next;
                            if (cnt == BITS_W'(WORD_W - 1)) begin
                                bus.word_out   <= sr_next;
                                bus.word_bits  <= BITS_W'(WORD_W);
                                bus.word_port  <= port_q;
                                bus.word_valid <= 1'b1;
                                cnt            <= '0;
                            end else begin
                                cnt <= cnt + BITS_W'(1);
                            end
                        end
                    end
                end
                FLUSH: begin
                    bus.word_out   <= sr & flush_mask;
                    bus.word_bits  <= cnt;
                    bus.word_port  <= port_q;
                    bus.word_valid <= 1'b1;
                    bus.frame_end  <= 1'b1;
                    bus.busy       <= 1'b0;
                    cnt            <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MSSD_FRAME_STATS_EN
    mssd_frame_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .frame_end (bus.frame_end),
        .port_q    (port_q),
        .frame_cnt (frame_cnt)
    );
`else
`endif

endmodule
